// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one buart
// transmitter between N byte-stream requesters.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   req_valid/last     per-requester byte offer and end-of-packet flag
//   req_data           8 bits per requester, requester i in [8i+7:8i]
//   req_ready          one-cycle accept strobe to the owning requester
//   uart_busy          buart busy (rises one cycle after uart_wr)
//   uart_wr/uart_data  one-cycle write strobe and byte to buart
//   grant_valid/idx    current owner (idx holds last owner when idle)
//   timeout_pulse      one-cycle pulse when a stalled grant is revoked
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int IDXW    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req_valid,
  input  logic [N-1:0]      req_last,
  input  logic [8*N-1:0]    req_data,
  output logic [N-1:0]      req_ready,
  input  logic              uart_busy,
  output logic              uart_wr,
  output logic [7:0]        uart_data,
  output logic              grant_valid,
  output logic [IDXW-1:0]   grant_idx,
  output logic              timeout_pulse
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_GUARD
  } state_t;

  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_t          state_q, state_d;
  logic [IDXW-1:0] gidx_q, gidx_d;
  logic            gval_q, gval_d;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [IDXW-1:0] cand;
  logic [IDXW-1:0] win_idx;
  logic            win_found;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;

  assign g_valid = req_valid[gidx_q];
  assign g_last  = req_last[gidx_q];

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gidx_q == IDXW'(i)) begin
        g_data = req_data[8*i +: 8];
      end
    end
  end

  // Search begins one past the last owner so it drops to lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = gidx_q;
    cand      = gidx_q;
    for (int k = 1; k <= N; k++) begin
      cand = IDXW'((int'(gidx_q) + k) % N);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gidx_d        = gidx_q;
    gval_d        = gval_q;
    data_d        = data_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    req_ready     = '0;
    timeout_pulse = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gidx_d  = win_idx;
          gval_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (g_valid && !uart_busy) begin
          req_ready[gidx_q] = 1'b1;
          data_d  = g_data;
          last_d  = g_last;
          cnt_d   = '0;
          state_d = S_SEND;
        end else if (!g_valid && TO != 16'd0) begin
          // Only a missing byte counts as a stall, never busy.
          if (cnt_q >= TO - 16'd1) begin
            timeout_pulse = 1'b1;
            gval_d        = 1'b0;
            cnt_d         = TO;
            state_d       = S_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_SEND: begin
        state_d = S_GUARD;
      end
      S_GUARD: begin
        // buart busy is not yet valid here.
        if (last_q) begin
          gval_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gidx_q  <= IDXW'(N - 1);
      gval_q  <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      gval_q  <= gval_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign uart_wr     = (state_q == S_SEND);
  assign uart_data   = data_q;
  assign grant_valid = gval_q;
  assign grant_idx   = gidx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized requesters and buart busy model,
// packet-level round-robin reference model with a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int IDXW    = 2;
  localparam int TIMEOUT = 10;

  typedef struct packed {
    logic [7:0] gap;
    logic       l;
    logic [7:0] d;
  } ent_t;

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [7:0]      d;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            uart_busy = 1'b0;
  logic            uart_wr;
  logic [7:0]      uart_data;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic            timeout_pulse;

  logic       v_a [N];
  logic       l_a [N];
  logic [7:0] d_a [N];

  ent_t drv_q [N][$];
  ent_t mdl_q [N][$];
  exp_t exp_q [$];
  int   vcyc [N][$];
  int   rdy_cyc [N][$];
  int   wr_cyc [$];
  int   wr_own [$];
  int   to_cyc [$];
  int   rdy_cnt [N];
  int   sent_cnt [N];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int busy_len = 0;
  int last_owner = N - 1;
  int to_total = 0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_valid[g]        = v_a[g];
    assign req_last[g]         = l_a[g];
    assign req_data[8*g +: 8]  = d_a[g];
  end

  uart_tx_arbiter #(
    .N(N), .IDXW(IDXW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_data(req_data),
    .req_ready(req_ready),
    .uart_busy(uart_busy),
    .uart_wr(uart_wr),
    .uart_data(uart_data),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d,
                           input logic l, input int gap);
    ent_t e;
    e.d   = d;
    e.l   = l;
    e.gap = 8'(gap);
    drv_q[r].push_back(e);
    mdl_q[r].push_back(e);
    sent_cnt[r]++;
  endtask

  // Requester drivers: offer each queued byte until accepted.
  for (genvar g = 0; g < N; g++) begin : g_drv
    initial begin
      ent_t e;
      int   budget;
      v_a[g] = 1'b0;
      l_a[g] = 1'b0;
      d_a[g] = 8'h00;
      forever begin
        @(posedge clk);
        #1;
        while (drv_q[g].size() > 0 && !reset) begin
          e = drv_q[g].pop_front();
          v_a[g] = 1'b0;
          repeat (int'(e.gap)) begin
            @(posedge clk);
            #1;
          end
          d_a[g] = e.d;
          l_a[g] = e.l;
          v_a[g] = 1'b1;
          vcyc[g].push_back(cyc);
          budget = 0;
          do begin
            @(negedge clk);
            budget++;
          end while (!req_ready[g] && !reset && budget < 3000);
          if (!reset) check("ready_wait", 32'(req_ready[g]), 32'd1);
          @(posedge clk);
          #1;
          v_a[g] = 1'b0;
        end
      end
    end
  end

  // buart model: busy rises the cycle after wr, lasts busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_wr && !reset && busy_len > 0) begin
        @(posedge clk);
        #1 uart_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 uart_busy = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pop on wr, reference arbitration when idle.
  initial begin
    exp_t x;
    int   w;
    int   c;
    ent_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (req_ready != '0) begin
          check("ready_vec", 32'(req_ready), 32'(1 << last_owner));
          for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
              rdy_cnt[i]++;
              rdy_cyc[i].push_back(cyc);
            end
          end
        end
        if (uart_wr) begin
          wr_cyc.push_back(cyc);
          wr_own.push_back(int'(grant_idx));
          check("wr_while_busy", 32'(uart_busy), 32'd0);
          if (exp_q.size() == 0) begin
            check("wr_unexpected", 32'd1, 32'd0);
          end else begin
            x = exp_q.pop_front();
            check("wr_data", 32'(uart_data), 32'(x.d));
            check("wr_owner", 32'(grant_idx), 32'(x.idx));
          end
        end
        if (timeout_pulse) begin
          to_cyc.push_back(cyc);
          to_total++;
        end
        if (!grant_valid && req_valid != '0) begin
          w = -1;
          for (int k = 1; k <= N; k++) begin
            c = (last_owner + k) % N;
            if (w < 0 && req_valid[c]) w = c;
          end
          last_owner = w;
          // Whole packet of the winner goes out before anyone else.
          while (mdl_q[w].size() > 0) begin
            e = mdl_q[w].pop_front();
            x.idx = IDXW'(w);
            x.d   = e.d;
            exp_q.push_back(x);
            if (e.l) break;
          end
        end
      end
    end
  end

  function automatic bit settled();
    bit ok;
    ok = (exp_q.size() == 0) && !grant_valid;
    for (int i = 0; i < N; i++) begin
      if (rdy_cnt[i] != sent_cnt[i] || drv_q[i].size() != 0) ok = 0;
    end
    return ok;
  endfunction

  task automatic drain(input string name);
    int b;
    b = 0;
    while (b < 5000 && !settled()) begin
      @(negedge clk);
      b++;
    end
    check(name, 32'(b < 5000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    last_owner = N - 1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int h;
    int b;
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int b;
    repeat (2) @(negedge clk);
    check("rst_wr", 32'(uart_wr), 32'd0);
    check("rst_data", 32'(uart_data), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_gval", 32'(grant_valid), 32'd0);
    check("rst_to", 32'(timeout_pulse), 32'd0);
    check("rst_gidx", 32'(grant_idx), 32'(N - 1));
    @(posedge clk);
    #1 reset = 1'b0;

    // Single requester, two-byte packet, busy low.
    wr_cyc.delete();
    push_byte(1, 8'h41, 1'b0, 0);
    push_byte(1, 8'h42, 1'b1, 0);
    drain("t1_drain");
    check("t1_nwr", 32'(wr_cyc.size()), 32'd2);
    if (wr_cyc.size() == 2) begin
      check("t1_wr0_cyc", 32'(wr_cyc[0] - vcyc[1][0]), 32'd2);
      check("t1_wr1_cyc", 32'(wr_cyc[1] - vcyc[1][0]), 32'd5);
    end
    check("t1_gval", 32'(grant_valid), 32'd0);
    check("t1_gidx", 32'(grant_idx), 32'd1);

    // Two packets from reset, never interleaved.
    do_reset();
    push_byte(0, 8'hA0, 1'b0, 0);
    push_byte(0, 8'hA1, 1'b1, 0);
    push_byte(2, 8'hB0, 1'b0, 0);
    push_byte(2, 8'hB1, 1'b1, 0);
    drain("t2_drain");
    check("t2_gidx", 32'(grant_idx), 32'd2);

    // Continuous single-byte packets alternate between 0 and 1.
    wr_own.delete();
    for (int k = 0; k < 4; k++) begin
      push_byte(0, 8'(8'h10 + k), 1'b1, 0);
      push_byte(1, 8'(8'h20 + k), 1'b1, 0);
    end
    drain("t3_drain");
    check("t3_nwr", 32'(wr_own.size()), 32'd8);
    for (int k = 0; k < wr_own.size(); k++) begin
      check("t3_alt", 32'(wr_own[k]), 32'(k % 2));
    end

    // Long busy: no timeout, one ready per byte.
    busy_len = 20;
    to_cyc.delete();
    push_byte(2, 8'h31, 1'b0, 0);
    push_byte(2, 8'h32, 1'b0, 0);
    push_byte(2, 8'h33, 1'b1, 0);
    push_byte(3, 8'h34, 1'b1, 0);
    drain("t4_drain");
    check("t4_no_to", 32'(to_cyc.size()), 32'd0);
    check("t4_rdy2", 32'(rdy_cnt[2]), 32'(sent_cnt[2]));
    check("t4_rdy3", 32'(rdy_cnt[3]), 32'(sent_cnt[3]));
    busy_len = 0;

    // Owner stalls mid-packet; grant revoked on 10th stall cycle.
    push_byte(3, 8'hC5, 1'b0, 0);
    push_byte(0, 8'h5A, 1'b1, 4);
    b = 0;
    while (b < 200 && to_cyc.size() == 0) begin
      @(negedge clk);
      #1;
      b++;
    end
    check("t5_to_seen", 32'(to_cyc.size()), 32'd1);
    if (to_cyc.size() > 0 && rdy_cyc[3].size() > 0) begin
      h = rdy_cyc[3][rdy_cyc[3].size() - 1];
      check("t5_to_cyc", 32'(to_cyc[0] - h), 32'd12);
      @(negedge clk);
      check("t5_idle_gval", 32'(grant_valid), 32'd0);
      @(negedge clk);
      check("t5_regrant", 32'(grant_valid), 32'd1);
      check("t5_regrant_idx", 32'(grant_idx), 32'd0);
    end
    drain("t5_drain");
    check("t5_pulse_width", 32'(to_cyc.size()), 32'd1);

    // Reset asserted while the byte is being written.
    push_byte(1, 8'h66, 1'b1, 0);
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!uart_wr && b < 50);
    check("t6_saw_wr", 32'(uart_wr), 32'd1);
    #2 reset = 1'b1;
    last_owner = N - 1;
    #1;
    check("t6_wr_drop", 32'(uart_wr), 32'd0);
    check("t6_gidx", 32'(grant_idx), 32'(N - 1));
    check("t6_gval", 32'(grant_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wr_own.delete();
    push_byte(0, 8'h70, 1'b1, 0);
    push_byte(1, 8'h71, 1'b1, 0);
    drain("t6_drain");
    check("t6_nwr", 32'(wr_own.size()), 32'd2);
    if (wr_own.size() == 2) begin
      check("t6_first", 32'(wr_own[0]), 32'd0);
      check("t6_second", 32'(wr_own[1]), 32'd1);
    end

    // Randomized traffic against the reference model.
    for (int round = 0; round < 6; round++) begin
      busy_len = int'($urandom_range(0, 4));
      for (int r = 0; r < N; r++) begin
        int np;
        np = int'($urandom_range(0, 2));
        for (int p = 0; p < np; p++) begin
          int len;
          len = int'($urandom_range(1, 4));
          for (int k = 0; k < len; k++) begin
            push_byte(r, 8'($urandom), k == len - 1,
                      k == 0 ? int'($urandom_range(0, 6))
                             : int'($urandom_range(0, 3)));
          end
        end
      end
      drain("rand_drain");
    end

    check("to_total", 32'(to_total), 32'd1);
    for (int i = 0; i < N; i++) begin
      check("rdy_total", 32'(rdy_cnt[i]), 32'(sent_cnt[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
